matrix_frame_buffer: RTL
========================

MATRIX_FRAME_BUFFER -- requirements
Module: matrix_frame_buffer

Interface
REQ-001 Parameter ROWS, default 8, number of matrix rows; only 8 is supported.
REQ-002 Parameter COLS, default 8, bits per row; only 8 is supported.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port wrValid, input, 1, the write request for one row.
REQ-006 Port wrReady, output, 1, the block can accept a row write.
REQ-007 Port wrRow, input, 3, the target row index in the back buffer.
REQ-008 Port wrData, input, 8, the row pixels; bit c is column c.
REQ-009 Port wrLast, input, 1, marks the final row write of a frame.
REQ-010 Port frameTick, input, 1, the one-cycle frame-rate enable pulse from the timer chain.
REQ-011 Port matrixOut, output, 64, the displayed frame for the row/column scan controller; row r occupies bits [8r+7:8r].
REQ-012 Port frameSwapped, output, 1, a one-cycle pulse in the cycle after the front buffer updates.
REQ-013 Port missedFrames, output, 8, a saturating count of frameTick pulses that arrived with no completed frame.

Function
REQ-014 The block SHALL hold a back buffer and a front buffer, each 64 bits; matrixOut SHALL derive only from the front buffer.
REQ-015 The FSM SHALL have two states, FILL and PENDING; wrReady SHALL equal 1 exactly in FILL.
REQ-016 An accepted write is wrValid&&wrReady. It SHALL write wrData into back row wrRow at the next edge. Any row order is allowed, and rows may be rewritten.
REQ-017 An accepted write with wrLast=1 SHALL move the FSM from FILL to PENDING at the same edge.
REQ-018 In PENDING, frameTick=1 SHALL copy back to front, return the FSM to FILL, and set frameSwapped=1 for the following cycle.
REQ-019 matrixOut SHALL reflect the new frame one cycle after the frameTick that triggers the swap.
REQ-020 In FILL, frameTick=1 SHALL leave the front buffer unchanged and SHALL increment missedFrames, which saturates at 255.
REQ-021 When frameTick and an accepted wrLast occur in the same FILL cycle, the tick SHALL count as missed and the FSM SHALL enter PENDING.
REQ-022 The back buffer SHALL retain its contents after a swap, so a partial rewrite followed by wrLast displays the merged frame.
REQ-023 Writes presented in PENDING SHALL be ignored and SHALL NOT modify the back buffer.

Reset
REQ-024 While rst=1, the block SHALL clear front, back, and missedFrames, clear frameSwapped and the scroll offset, and set the FSM to FILL; after reset, matrixOut=0 and wrReady=1.
REQ-025 A reset asserted mid-frame or in PENDING SHALL discard the pending frame, with no swap and no frameSwapped pulse.

Configuration
REQ-026 When MATRIX_SCROLL_EN is defined, the block SHALL add input port scrollTick (1 bit) and a 3-bit offset register.
- The offset increments on scrollTick, wraps 7->0, and resets to 0 on every swap.
- Each row of matrixOut is the front row rotated left by offset; column c is output at position (c+offset) mod 8.
REQ-027 When MATRIX_SCROLL_EN is undefined, the scrollTick port and offset register SHALL be absent, and matrixOut SHALL equal the front buffer.

Structure
REQ-028 The shared package matrix_pkg SHALL hold ROWS, COLS, the row-index width, the FSM state enum {FILL, PENDING}, and the missedFrames width.
REQ-029 Row rotation SHALL be a single combinational sub-module row_rotate (8-bit data, 3-bit offset), instantiated once per row.

Verification
REQ-030 Reset then idle: matrixOut=0, wrReady=1, missedFrames=0, frameSwapped=0.
REQ-031 Write rows 0..7 = 0x01,0x02,...,0x80, with wrLast on row 7, then frameTick: wrReady=0 until the tick; matrixOut=0x8040201008040201 one cycle after the tick; frameSwapped pulses once.
REQ-032 Three frameTicks in FILL with no frame, then 300 ticks: missedFrames=3, then saturates at 255; matrixOut is unchanged.
REQ-033 wrLast accepted in the same cycle as frameTick: missedFrames increments by 1, the FSM enters PENDING, and the frame appears on the next tick.
REQ-034 Write row 2=0xFF, then assert rst mid-frame, then write a full frame of 0x00 rows: after the swap matrixOut=0, and no stale 0xFF remains.
REQ-035 (MATRIX_SCROLL_EN) With front row 0=0x01, apply 3 scrollTicks: row 0 output=0x08; after 8 ticks it returns to 0x01; a swap resets the offset to 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared sizes and FSM state for the matrix frame buffer
package matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int MISS_W = 8;
  typedef enum logic {FILL, PENDING} state_t;
endpackage

// File: rtl/matrix_frame_buffer_row_rotate.sv
// row_rotate: rotates one row left by a column offset (bit c lands at (c+off) mod COLS)
module row_rotate
  import matrix_pkg::*;
(
  input  logic [COLS-1:0]  i_data,
  input  logic [COL_W-1:0] i_off,
  output logic [COLS-1:0]  o_data
);
  logic [2*COLS-1:0] w_dbl;
  assign w_dbl = {i_data, i_data} << i_off;
  assign o_data = w_dbl[2*COLS-1:COLS];
endmodule

// File: rtl/matrix_frame_buffer.sv
// matrix_frame_buffer: double-buffered 8x8 frame store swapped on frameTick
// Define MATRIX_SCROLL_EN to add scrollTick and a per-row left-rotate offset.
module matrix_frame_buffer
  import matrix_pkg::state_t;
  import matrix_pkg::FILL;
  import matrix_pkg::PENDING;
  import matrix_pkg::ROW_W;
  import matrix_pkg::COL_W;
  import matrix_pkg::MISS_W;
#(
  parameter int ROWS = matrix_pkg::ROWS,
  parameter int COLS = matrix_pkg::COLS
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MATRIX_SCROLL_EN
  input  logic                 scrollTick,
`endif
  input  logic                 wrValid,
  output logic                 wrReady,
  input  logic [ROW_W-1:0]     wrRow,
  input  logic [COLS-1:0]      wrData,
  input  logic                 wrLast,
  input  logic                 frameTick,
  output logic [ROWS*COLS-1:0] matrixOut,
  output logic                 frameSwapped,
  output logic [MISS_W-1:0]    missedFrames
);
  state_t r_state;
  logic [ROWS*COLS-1:0] r_front, r_back;
  logic [MISS_W-1:0] r_missed;
  logic r_swapped;
  logic w_acc, w_swap;
  logic [COL_W-1:0] w_off;
  assign wrReady = r_state == FILL;
  assign w_acc = wrValid && wrReady;
  assign w_swap = r_state == PENDING && frameTick;
  assign frameSwapped = r_swapped;
  assign missedFrames = r_missed;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_front <= '0;
      r_back <= '0;
      r_missed <= '0;
      r_swapped <= 1'b0;
    end else begin
      r_swapped <= w_swap;
      if (w_acc) r_back[wrRow*COLS +: COLS] <= wrData;
      if (r_state == FILL) begin
        if (frameTick && r_missed != '1) r_missed <= r_missed + 1'b1;
        if (w_acc && wrLast) r_state <= PENDING;
      end else if (frameTick) begin
        r_front <= r_back;
        r_state <= FILL;
      end
    end
  end
`ifdef MATRIX_SCROLL_EN
  logic [COL_W-1:0] r_off;
  always_ff @(posedge clk) begin
    if (rst || w_swap) r_off <= '0;
    else if (scrollTick) r_off <= r_off + 1'b1;
  end
  assign w_off = r_off;
`else
  assign w_off = '0;
`endif
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    row_rotate u_rot (
      .i_data(r_front[r*COLS +: COLS]),
      .i_off (w_off),
      .o_data(matrixOut[r*COLS +: COLS])
    );
  end
endmodule
